divider_seq_stage: RTL and testbench
====================================

Name: divider_seq_stage

Overview:
- Sequential front/back-end for the combinational array `divider` (dividend `DEVIDENT_LENGTH`, divisor `DIVISOR_LENGTH`).
- Accepts operand pairs over a valid/ready handshake and registers them onto the divider inputs.
- Waits a programmable settle time for the ripple array, then captures `Quotient`/`Remainder` into output registers.
- Presents the results downstream with valid/ready back-pressure and a divide-by-zero flag.

Parameters:
- DEVIDENT_LENGTH, 6, dividend and quotient width.
- DIVISOR_LENGTH, 3, divisor and remainder width.
- SETTLE_CYCLES, 2, clock cycles allowed for the array to settle; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept an operand pair this cycle.
- in_dividend  input  DEVIDENT_LENGTH  dividend.
- in_divisor  input  DIVISOR_LENGTH  divisor.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes the result this cycle.
- out_quotient  output  DEVIDENT_LENGTH  registered quotient.
- out_remainder  output  DIVISOR_LENGTH  registered remainder.
- out_div_by_zero  output  1  result came from divisor == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (clk and rst are the only clock/reset; reset is synchronous and active-high):
  - rst sampled high at a rising edge sets: state = IDLE, counter = 0, operand registers = 0, out_valid = 0, out_quotient = 0, out_remainder = 0, out_div_by_zero = 0.
  - rst overrides every other input, including mid-COMPUTE and DONE. An in-flight operation is discarded; no output pulse follows.
- Handshakes:
  - Input transfer ("accept") = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
  - in_ready = (state == IDLE) || (state == DONE && out_ready); combinational, no dependence on in_valid.
  - out_valid = (state == DONE); the out_* registers hold stable while out_valid && !out_ready.
- States:
  - IDLE:
    - on accept: latch operands, counter = SETTLE_CYCLES-1, go COMPUTE.
    - otherwise stay.
  - COMPUTE:
    - the divider is fed only from the operand registers.
    - if counter != 0: decrement.
    - if counter == 0: capture divider outputs into out_quotient/out_remainder and go DONE.
    - in_valid is ignored (in_ready = 0).
  - DONE:
    - on output transfer with a simultaneous accept: latch the new operands, reload counter, go COMPUTE (zero bubble on the input side).
    - on output transfer alone: go IDLE.
    - otherwise stay in DONE and hold.
- Latency:
  - Accept at edge N gives out_valid high from edge N+SETTLE_CYCLES.
  - Sustained throughput is one result per SETTLE_CYCLES+1 cycles with out_ready held high.
- Divide by zero:
  - Detected from the latched divisor == 0.
  - Capture then forces out_quotient = all ones and out_remainder = latched dividend[DIVISOR_LENGTH-1:0], and sets out_div_by_zero = 1.
  - Latency is identical to the normal path.
  - out_div_by_zero = 0 for every other result.
- Width rules: no truncation or extension; the quotient is always DEVIDENT_LENGTH bits and the remainder DIVISOR_LENGTH bits.
- The counter is $clog2(SETTLE_CYCLES+1) bits wide, minimum 1.

Decomposition:
- Package divider_seq_pkg:
  - state enum {IDLE, COMPUTE, DONE}, 2-bit encoding.
  - SETTLE_CYCLES legality check.
  - counter-width function.
- Sub-module: the existing `divider`, instantiated once and driven by the operand registers.
- FSM, counter, and output registers live in divider_seq_stage itself.

Test Plan:
- rst high for 2 cycles, then low -> out_valid=0, out_quotient=0, out_remainder=0, in_ready=1, busy=0.
- Accept 45 / 6 with out_ready=1 -> out_valid rises exactly 2 cycles later with quotient=7, remainder=3, div_by_zero=0; returns to IDLE after 1 cycle.
- Accept 10 / 0 -> quotient=63, remainder=2, div_by_zero=1, same 2-cycle latency.
- Back-pressure: accept 63 / 7, hold out_ready=0 for 5 cycles -> quotient=9 and remainder=0 held stable with out_valid=1 and in_ready=0; release, output transfer occurs, state IDLE.
- Back-to-back: in_valid held high with pairs 45/6 then 20/3, out_ready=1 -> second accept on the same edge as the first output transfer; results 7r3 then 6r2, spaced 3 cycles apart.
- Reset mid-COMPUTE: accept 45/6, assert rst on the next edge -> no out_valid pulse ever appears; next accept of 20/3 produces 6r2 with normal latency.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared types and elaboration helpers for the sequential divider stage.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  function automatic bit settle_ok(input int settle);
    return (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

  // Counter must hold SETTLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/divider.sv
// Combinational restoring array divider; outputs ripple through DEVIDENT_LENGTH subtract stages.
module divider #(
  parameter int DEVIDENT_LENGTH = 6,
  parameter int DIVISOR_LENGTH  = 3
) (
  input  logic [DEVIDENT_LENGTH-1:0] Dividend,
  input  logic [DIVISOR_LENGTH-1:0]  Divisor,
  output logic [DEVIDENT_LENGTH-1:0] Quotient,
  output logic [DIVISOR_LENGTH-1:0]  Remainder
);

  logic [DIVISOR_LENGTH:0] part;

  always_comb begin
    part     = '0;
    Quotient = '0;
    for (int i = DEVIDENT_LENGTH - 1; i >= 0; i--) begin
      part = {part[DIVISOR_LENGTH-1:0], Dividend[i]};
      if (part >= {1'b0, Divisor}) begin
        part        = part - {1'b0, Divisor};
        Quotient[i] = 1'b1;
      end
    end
    Remainder = part[DIVISOR_LENGTH-1:0];
  end

endmodule

// File: rtl/divider_seq_stage.sv
// Registers operands onto the array divider, waits SETTLE_CYCLES, then captures the result
// and holds it under valid/ready back-pressure; a new operand may enter on the draining edge.
module divider_seq_stage
  import divider_seq_pkg::*;
#(
  parameter int DEVIDENT_LENGTH = 6,
  parameter int DIVISOR_LENGTH  = 3,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DEVIDENT_LENGTH-1:0] in_dividend,
  input  logic [DIVISOR_LENGTH-1:0]  in_divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DEVIDENT_LENGTH-1:0] out_quotient,
  output logic [DIVISOR_LENGTH-1:0]  out_remainder,
  output logic                       out_div_by_zero,
  output logic                       busy
);

  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  if (!settle_ok(SETTLE_CYCLES)) begin : g_settle_check
    $error("divider_seq_stage: SETTLE_CYCLES must be within 1..15");
  end

  state_t                     state, next_state;
  logic [CW-1:0]              counter;
  logic [DEVIDENT_LENGTH-1:0] op_dividend;
  logic [DIVISOR_LENGTH-1:0]  op_divisor;
  logic [DEVIDENT_LENGTH-1:0] div_quotient;
  logic [DIVISOR_LENGTH-1:0]  div_remainder;
  logic                       load;
  logic                       capture;

  // The array only ever sees the registered operands, so it is stable for the whole settle window.
  divider #(
    .DEVIDENT_LENGTH (DEVIDENT_LENGTH),
    .DIVISOR_LENGTH  (DIVISOR_LENGTH)
  ) u_divider (
    .Dividend  (op_dividend),
    .Divisor   (op_divisor),
    .Quotient  (div_quotient),
    .Remainder (div_remainder)
  );

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        if (counter == '0) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            load       = 1'b1;
            next_state = COMPUTE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      counter         <= '0;
      op_dividend     <= '0;
      op_divisor      <= '0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        op_dividend <= in_dividend;
        op_divisor  <= in_divisor;
        counter     <= RELOAD;
      end else if ((state == COMPUTE) && (counter != '0)) begin
        counter <= counter - CW'(1);
      end
      if (capture) begin
        if (op_divisor == '0) begin
          out_quotient    <= '1;
          out_remainder   <= op_dividend[DIVISOR_LENGTH-1:0];
          out_div_by_zero <= 1'b1;
        end else begin
          out_quotient    <= div_quotient;
          out_remainder   <= div_remainder;
          out_div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_seq_stage.sv
// Directed bench for divider_seq_stage with default parameters (6/3 bits, 2 settle cycles).
module tb_divider_seq_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_dividend = '0;
  logic [2:0] in_divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_quotient;
  logic [2:0] out_remainder;
  logic       out_div_by_zero;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divider_seq_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_dividend     (in_dividend),
    .in_divisor      (in_divisor),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_quotient    (out_quotient),
    .out_remainder   (out_remainder),
    .out_div_by_zero (out_div_by_zero),
    .busy            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (out_quotient !== 6'd0) begin n_fail++; $display("FAIL reset_quotient got %0d want 0", out_quotient); end
    n_tests++; if (out_remainder !== 3'd0) begin n_fail++; $display("FAIL reset_remainder got %0d want 0", out_remainder); end
    n_tests++; if (out_div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %0b want 0", out_div_by_zero); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 6'd45;
    in_divisor  = 3'd6;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_n0 got valid=%0b busy=%0b want valid=0 busy=1", out_valid, busy); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_compute_in_ready got %0b want 0", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_n1_valid got %0b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_n2_valid got %0b want 1", out_valid); end
    n_tests++; if (out_quotient !== 6'd7 || out_remainder !== 3'd3) begin n_fail++; $display("FAIL basic_result got %0dr%0d want 7r3", out_quotient, out_remainder); end
    n_tests++; if (out_div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %0b want 0", out_div_by_zero); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_div_by_zero();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 6'd10;
    in_divisor  = 3'd0;
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dbz_n1_valid got %0b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dbz_n2_valid got %0b want 1", out_valid); end
    n_tests++; if (out_quotient !== 6'd63 || out_remainder !== 3'd2) begin n_fail++; $display("FAIL dbz_result got %0dr%0d want 63r2", out_quotient, out_remainder); end
    n_tests++; if (out_div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %0b want 1", out_div_by_zero); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_dividend = 6'd63;
    in_divisor  = 3'd7;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_quotient !== 6'd9 || out_remainder !== 3'd0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got valid=%0b %0dr%0d in_ready=%0b want valid=1 9r0 in_ready=0",
                 i, out_valid, out_quotient, out_remainder, in_ready);
      end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 6'd45;
    in_divisor  = 3'd6;
    tick();
    in_dividend = 6'd20;
    in_divisor  = 3'd3;
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_quotient !== 6'd7 || out_remainder !== 3'd3) begin n_fail++; $display("FAIL b2b_first got valid=%0b %0dr%0d want 1 7r3", out_valid, out_quotient, out_remainder); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept got valid=%0b busy=%0b want 0 1", out_valid, busy); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got valid=%0b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_quotient !== 6'd6 || out_remainder !== 3'd2) begin n_fail++; $display("FAIL b2b_second got valid=%0b %0dr%0d want 1 6r2", out_valid, out_quotient, out_remainder); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid_compute();
    int pulses;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 6'd45;
    in_divisor  = 3'd6;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) pulses++;
      tick();
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_no_pulse got %0d pulses want 0", pulses); end
    n_tests++; if (busy !== 1'b0 || out_quotient !== 6'd0) begin n_fail++; $display("FAIL rstmid_state got busy=%0b q=%0d want 0 0", busy, out_quotient); end
    in_valid    = 1'b1;
    in_dividend = 6'd20;
    in_divisor  = 3'd3;
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_n1_valid got %0b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_quotient !== 6'd6 || out_remainder !== 3'd2) begin n_fail++; $display("FAIL rstmid_result got valid=%0b %0dr%0d want 1 6r2", out_valid, out_quotient, out_remainder); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_compute();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
